// File: rtl/cnn_pkg.sv
// Network geometry and datapath widths shared by the CNN streaming stages.
package cnn_pkg;

  localparam int CONV_OUT_W = 24;
  localparam int CONV_OUT_H = 24;
  localparam int POOL_OUT_W = CONV_OUT_W / 2;
  localparam int POOL_OUT_H = CONV_OUT_H / 2;
  localparam int CO         = 3;
  localparam int ACC_W      = 23;
  localparam int ACT_W      = 8;
  localparam int REQ_SHIFT  = 8;

endpackage

// File: rtl/pool_channel.sv
// One channel of ReLU + 2x2 max pooling: horizontal hold register, a line
// buffer of horizontal maxima and the requantizer to an unsigned activation.
module pool_channel
  import cnn_pkg::*;
#(
  parameter int I_BW  = ACC_W,
  parameter int O_BW  = ACT_W,
  parameter int OW    = POOL_OUT_W,
  parameter int SHIFT = REQ_SHIFT
) (
  input  logic                        clk,
  input  logic                        i_en,
  input  logic                        i_x_odd,
  input  logic                        i_y_odd,
  input  logic [$clog2(OW)-1:0]       i_idx,
  input  logic signed [I_BW-1:0]      i_sample,
  output logic [O_BW-1:0]             o_q
);

  localparam int U_BW = I_BW - 1;

  logic [U_BW-1:0] relu_v;
  logic [U_BW-1:0] hmax;
  logic [U_BW-1:0] pooled;
  logic [U_BW-1:0] hold_q, hold_d;
  logic [U_BW-1:0] lbuf_q [OW];
  logic [U_BW-1:0] lbuf_d [OW];

  function automatic logic [U_BW-1:0] umax(input logic [U_BW-1:0] a,
                                           input logic [U_BW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Any bit surviving above the activation width after the shift saturates.
  function automatic logic [O_BW-1:0] requant(input logic [U_BW-1:0] v);
    logic [U_BW-1:0] q;
    q = v >> SHIFT;
    if (|(q >> O_BW)) return '1;
    return q[O_BW-1:0];
  endfunction

  always_comb begin
    relu_v = i_sample[I_BW-1] ? '0 : i_sample[U_BW-1:0];
    hmax   = umax(hold_q, relu_v);
    pooled = umax(lbuf_q[i_idx], hmax);
    hold_d = hold_q;
    lbuf_d = lbuf_q;
    if (i_en && !i_x_odd) hold_d = relu_v;
    if (i_en && i_x_odd && !i_y_odd) lbuf_d[i_idx] = hmax;
  end

  // Datapath storage only; even rows always overwrite before odd rows read.
  always_ff @(posedge clk) begin
    hold_q <= hold_d;
    lbuf_q <= lbuf_d;
  end

  assign o_q = requant(pooled);

endmodule

// File: rtl/relu_maxpool2x2.sv
// Streaming ReLU + 2x2/2 max pool over a raster-ordered multi-channel map,
// emitting requantized 8-bit activations with output coordinates.
module relu_maxpool2x2 #(
  parameter int CO    = cnn_pkg::CO,
  parameter int I_BW  = cnn_pkg::ACC_W,
  parameter int O_BW  = cnn_pkg::ACT_W,
  parameter int IW    = cnn_pkg::CONV_OUT_W,
  parameter int IH    = cnn_pkg::CONV_OUT_H,
  parameter int SHIFT = cnn_pkg::REQ_SHIFT
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        i_clear,
  input  logic                        i_valid,
  input  logic [CO*I_BW-1:0]          i_fmap,
  output logic                        o_valid,
  output logic [CO*O_BW-1:0]          o_fmap,
  output logic [$clog2(IW/2)-1:0]     o_x,
  output logic [$clog2(IH/2)-1:0]     o_y,
  output logic                        o_frame_done
);

  import cnn_pkg::*;

  localparam int OW  = IW / 2;
  localparam int OH  = IH / 2;
  localparam int XW  = $clog2(IW);
  localparam int YW  = $clog2(IH);
  localparam int OXW = $clog2(OW);
  localparam int OYW = $clog2(OH);

  if ((IW % 2) != 0 || (IH % 2) != 0) begin : g_bad_geom
    $error("relu_maxpool2x2: IW and IH must both be even");
  end

  logic              accept;
  logic              x_last, y_last, complete;
  logic [XW-1:0]     x_cnt_q, x_cnt_d;
  logic [YW-1:0]     y_cnt_q, y_cnt_d;
  logic              o_valid_q, o_valid_d;
  logic              o_done_q, o_done_d;
  logic [CO*O_BW-1:0] o_fmap_q, o_fmap_d;
  logic [OXW-1:0]    o_x_q, o_x_d;
  logic [OYW-1:0]    o_y_q, o_y_d;
  logic [CO*O_BW-1:0] chan_q;

  for (genvar c = 0; c < CO; c++) begin : g_ch
    pool_channel #(
      .I_BW  (I_BW),
      .O_BW  (O_BW),
      .OW    (OW),
      .SHIFT (SHIFT)
    ) u_ch (
      .clk      (clk),
      .i_en     (accept),
      .i_x_odd  (x_cnt_q[0]),
      .i_y_odd  (y_cnt_q[0]),
      .i_idx    (x_cnt_q[XW-1:1]),
      .i_sample (i_fmap[c*I_BW +: I_BW]),
      .o_q      (chan_q[c*O_BW +: O_BW])
    );
  end

  always_comb begin
    accept   = i_valid && !i_clear;
    x_last   = (x_cnt_q == XW'(IW - 1));
    y_last   = (y_cnt_q == YW'(IH - 1));
    complete = accept && x_cnt_q[0] && y_cnt_q[0];

    x_cnt_d = x_cnt_q;
    y_cnt_d = y_cnt_q;
    if (i_clear) begin
      x_cnt_d = '0;
      y_cnt_d = '0;
    end else if (i_valid) begin
      x_cnt_d = x_last ? '0 : x_cnt_q + 1'b1;
      if (x_last) y_cnt_d = y_last ? '0 : y_cnt_q + 1'b1;
    end

    // Data fields hold between pulses; only valid/done are single-cycle.
    o_valid_d = complete;
    o_done_d  = complete && x_last && y_last;
    o_fmap_d  = o_fmap_q;
    o_x_d     = o_x_q;
    o_y_d     = o_y_q;
    if (complete) begin
      o_fmap_d = chan_q;
      o_x_d    = OXW'(x_cnt_q >> 1);
      o_y_d    = OYW'(y_cnt_q >> 1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_cnt_q   <= '0;
      y_cnt_q   <= '0;
      o_valid_q <= 1'b0;
      o_done_q  <= 1'b0;
      o_fmap_q  <= '0;
      o_x_q     <= '0;
      o_y_q     <= '0;
    end else begin
      x_cnt_q   <= x_cnt_d;
      y_cnt_q   <= y_cnt_d;
      o_valid_q <= o_valid_d;
      o_done_q  <= o_done_d;
      o_fmap_q  <= o_fmap_d;
      o_x_q     <= o_x_d;
      o_y_q     <= o_y_d;
    end
  end

  assign o_valid      = o_valid_q;
  assign o_frame_done = o_done_q;
  assign o_fmap       = o_fmap_q;
  assign o_x          = o_x_q;
  assign o_y          = o_y_q;

endmodule

// File: tb/tb_relu_maxpool2x2.sv
// Directed bench for relu_maxpool2x2 with a window-based reference model
// and an in-order scoreboard of expected pooled outputs.
module tb_relu_maxpool2x2;

  localparam int CO = 3, I_BW = 23, O_BW = 8, IW = 24, IH = 24, SHIFT = 8;

  typedef struct packed {
    logic [23:0] fmap;
    logic [3:0]  x;
    logic [3:0]  y;
    logic        done;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              i_clear = 1'b0;
  logic              i_valid = 1'b0;
  logic [CO*I_BW-1:0] i_fmap = '0;
  logic              o_valid;
  logic [CO*O_BW-1:0] o_fmap;
  logic [3:0]        o_x;
  logic [3:0]        o_y;
  logic              o_frame_done;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  logic drive_flag = 1'b0;
  logic exp_vld = 1'b0;
  int mx = 0, my = 0;
  int n_vld = 0, n_done = 0;
  logic [23:0] cap [12][12];
  logic signed [22:0] img [3][24][24];

  relu_maxpool2x2 #(
    .CO(CO), .I_BW(I_BW), .O_BW(O_BW), .IW(IW), .IH(IH), .SHIFT(SHIFT)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_clear      (i_clear),
    .i_valid      (i_valid),
    .i_fmap       (i_fmap),
    .o_valid      (o_valid),
    .o_fmap       (o_fmap),
    .o_x          (o_x),
    .o_y          (o_y),
    .o_frame_done (o_frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic signed [22:0] pix(input int kind, input int c, input int x, input int y);
    int k, wx, wy, v;
    k  = (y % 2) * 2 + (x % 2);
    wx = x / 2;
    wy = y / 2;
    v  = int'($urandom_range(0, 140000)) - 70000;
    if (kind == 0) v = (y * 24 + x) << 8;
    else if (kind == 1 && wy == 0) begin
      case (wx)
        0: case (k) 0: v = -5000; 1: v = -1; 2: v = -300; default: v = -7; endcase
        1: case (k) 0: v = -5000; 1: v = 512; 2: v = -1; default: v = 256; endcase
        2: v = (k == 2) ? 4194303 : -1;
        3: v = (c == 0) ? 1024 : ((c == 1) ? 0 : -1024);
        default: ;
      endcase
    end
    return 23'(v);
  endfunction

  function automatic logic [7:0] exp_ch(input int c, input int wx, input int wy);
    int m, v;
    m = 0;
    for (int dy = 0; dy < 2; dy++)
      for (int dx = 0; dx < 2; dx++) begin
        v = int'(img[c][2*wy+dy][2*wx+dx]);
        if (v > m) m = v;
      end
    m = m / 256;
    return (m > 255) ? 8'hff : 8'(m);
  endfunction

  task automatic send_px(input int kind);
    logic [CO*I_BW-1:0] d;
    exp_t e;
    for (int c = 0; c < CO; c++) begin
      img[c][my][mx] = pix(kind, c, mx, my);
      d[c*I_BW +: I_BW] = img[c][my][mx];
    end
    @(posedge clk); #1;
    i_valid = 1'b1;
    i_clear = 1'b0;
    i_fmap  = d;
    drive_flag = 1'b0;
    if ((mx % 2) == 1 && (my % 2) == 1) begin
      e.fmap = {exp_ch(2, mx/2, my/2), exp_ch(1, mx/2, my/2), exp_ch(0, mx/2, my/2)};
      e.x    = 4'(mx / 2);
      e.y    = 4'(my / 2);
      e.done = (mx == IW-1) && (my == IH-1);
      sb.push_back(e);
      drive_flag = 1'b1;
    end
    if (mx == IW-1) begin
      mx = 0;
      my = (my == IH-1) ? 0 : my + 1;
    end else mx++;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_clear = 1'b0;
    i_fmap  = {$urandom, $urandom, $urandom};
    drive_flag = 1'b0;
  endtask

  task automatic clr();
    @(posedge clk); #1;
    i_valid = 1'b1;
    i_clear = 1'b1;
    i_fmap  = {$urandom, $urandom, $urandom};
    drive_flag = 1'b0;
    mx = 0;
    my = 0;
  endtask

  task automatic frame(input int kind, input bit gaps, input int npx);
    for (int i = 0; i < npx; i++) begin
      if (gaps) while ($urandom_range(0, 99) < 30) idle();
      send_px(kind);
    end
  endtask

  always @(posedge clk or negedge reset_n)
    if (!reset_n) exp_vld <= 1'b0;
    else          exp_vld <= drive_flag;

  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      check("rst_valid", 32'(o_valid), 0);
      check("rst_done", 32'(o_frame_done), 0);
      check("rst_fmap", 32'(o_fmap), 0);
    end else begin
      check("valid", 32'(o_valid), 32'(exp_vld));
      if (o_valid) begin
        n_vld++;
        if (o_frame_done) n_done++;
        cap[o_y][o_x] = o_fmap;
      end else check("done_no_valid", 32'(o_frame_done), 0);
      if (exp_vld) begin
        if (sb.size() == 0) check("sb_underflow", 0, 1);
        else begin
          e = sb.pop_front();
          if (o_valid) begin
            check("fmap", 32'(o_fmap), 32'(e.fmap));
            check("o_x", 32'(o_x), 32'(e.x));
            check("o_y", 32'(o_y), 32'(e.y));
            check("frame_done", 32'(o_frame_done), 32'(e.done));
          end
        end
      end
    end
  end

  initial begin
    int base_v, base_d;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_x", 32'(o_x), 0);
    check("rst_y", 32'(o_y), 0);
    @(posedge clk); #3 reset_n = 1'b1;

    // Ramp frame, contiguous
    base_v = n_vld; base_d = n_done;
    frame(0, 1'b0, IW*IH);
    repeat (3) idle();
    check("ramp_count", 32'(n_vld - base_v), 144);
    check("ramp_done_count", 32'(n_done - base_d), 1);
    check("ramp_00", 32'(cap[0][0]), 32'h191919);
    check("ramp_10", 32'(cap[0][1]), 32'h1b1b1b);
    check("ramp_1111_sat", 32'(cap[11][11]), 32'hffffff);

    // ReLU, saturation, channel independence
    frame(1, 1'b0, IW*IH);
    repeat (3) idle();
    check("relu_all_neg", 32'(cap[0][0]), 0);
    check("relu_mixed", 32'(cap[0][1]), 32'h020202);
    check("sat_max", 32'(cap[0][2]), 32'hffffff);
    check("chan_indep", 32'(cap[0][3]), 32'h000004);

    // Two back-to-back frames with random gaps
    base_v = n_vld; base_d = n_done;
    frame(2, 1'b1, 2*IW*IH);
    repeat (3) idle();
    check("gap_count", 32'(n_vld - base_v), 288);
    check("gap_done_count", 32'(n_done - base_d), 2);

    // Abort mid-frame; the clear lands on a window-completing pixel
    frame(2, 1'b0, 121);
    clr();
    @(negedge clk);
    check("clear_no_valid", 32'(o_valid), 0);
    base_v = n_vld; base_d = n_done;
    frame(0, 1'b0, IW*IH);
    repeat (3) idle();
    check("clear_count", 32'(n_vld - base_v), 144);
    check("clear_done_count", 32'(n_done - base_d), 1);
    check("clear_row0", 32'(cap[0][0]), 32'h191919);

    // Asynchronous reset while an output is being presented
    frame(2, 1'b0, IW + 4);
    @(posedge clk); #1;
    check("pre_rst_valid", 32'(o_valid), 1);
    #1;
    reset_n = 1'b0;
    i_valid = 1'b0;
    drive_flag = 1'b0;
    sb.delete();
    mx = 0;
    my = 0;
    #1;
    check("rst_drop_valid", 32'(o_valid), 0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    base_v = n_vld; base_d = n_done;
    frame(0, 1'b0, IW*IH);
    repeat (3) idle();
    check("post_rst_count", 32'(n_vld - base_v), 144);
    check("post_rst_done_count", 32'(n_done - base_d), 1);
    check("post_rst_00", 32'(cap[0][0]), 32'h191919);
    check("sb_drained", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
